// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the skid-buffered pipeline register.
//   - pipe_state_e : occupancy state (EMPTY / BUSY / FULL)
//   - pipe_count_t : 2-bit count of held payloads (0..2)
//   - SIZE_DEFAULT : default payload width
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int SIZE_DEFAULT = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // nothing held
      BUSY  = 2'd1,   // main register holds a payload
      FULL  = 2'd2    // main and skid registers both hold payloads
   } pipe_state_e;

   typedef logic [1:0] pipe_count_t;

endpackage : pipe_pkg

// File: rtl/pipe_data_reg.sv
// ---------------------------------------------------------------------------
// pipe_data_reg
//   SIZE-wide storage register, loaded when en_i is high, cleared to zero by
//   asynchronous active-low reset.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : asynchronous active-low reset
//     en_i   : load enable
//     d_i    : value loaded when en_i=1
//     q_o    : stored value
// ---------------------------------------------------------------------------
module pipe_data_reg #(
   parameter int SIZE = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic [SIZE-1:0] d_i,
   output logic [SIZE-1:0] q_o
);

   logic [SIZE-1:0] data_d;
   logic [SIZE-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (en_i) begin
         data_d = d_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule : pipe_data_reg

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Pipeline register stage with one skid entry. in_ready_o is registered so
//   there is no combinational path from out_ready_i back to in_ready_o; the
//   skid register absorbs the one payload that can arrive in the cycle the
//   downstream stalls.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. A producer holds valid and data stable until accepted.
//
//   Optional feature (macro PIPE_SKID_FLUSH_EN): adds flush_i, a synchronous
//   flush that empties the stage and drops any same-cycle input. Without the
//   macro the port is absent and the stage behaves as if flush_i were 0.
//
//   Ports:
//     clk_i        : clock, rising edge
//     rst_i        : asynchronous active-low reset
//     in_valid_i   : upstream payload valid
//     in_data_i    : upstream payload
//     in_ready_o   : stage can accept (registered)
//     out_valid_o  : stage holds a payload
//     out_data_o   : payload to downstream (main register)
//     out_ready_i  : downstream accepts
//     flush_i      : synchronous flush (PIPE_SKID_FLUSH_EN only)
//     count_o      : number of held payloads, 0..2
//     dbg_state_o  : current occupancy state, for observation
// ---------------------------------------------------------------------------
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int SIZE = SIZE_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   input  logic [SIZE-1:0] in_data_i,
   output logic            in_ready_o,
   output logic            out_valid_o,
   output logic [SIZE-1:0] out_data_o,
   input  logic            out_ready_i,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic            flush_i,
`endif
   output pipe_count_t     count_o,
   output pipe_state_e     dbg_state_o
);

   pipe_state_e     state_d, state_q;
   logic            in_ready_d, in_ready_q;
   logic            flush;
   logic            in_xfer, out_xfer;
   logic            main_en, skid_en;
   logic [SIZE-1:0] main_d, main_q, skid_q;

`ifdef PIPE_SKID_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   assign in_xfer  = in_valid_i & in_ready_q;
   assign out_xfer = out_valid_o & out_ready_i;

   // Draining FULL moves the skid entry forward; otherwise main loads input.
   assign main_d = (state_q == FULL) ? skid_q : in_data_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Next state and register load enables
   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = BUSY;
               main_en = 1'b1;
            end
         end
         BUSY: begin
            if (in_xfer && out_xfer) begin
               main_en = 1'b1;
            end else if (in_xfer) begin
               state_d = FULL;
               skid_en = 1'b1;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_d = BUSY;
               main_en = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      // Flush wins over everything; data registers keep their contents.
      if (flush) begin
         state_d = EMPTY;
         main_en = 1'b0;
         skid_en = 1'b0;
      end
   end

   // Ready is derived from the next state so it can be registered.
   always_comb begin
      in_ready_d = (state_d != FULL);
   end

   // Outputs
   always_comb begin
      out_valid_o = (state_q != EMPTY);
      dbg_state_o = state_q;
      case (state_q)
         BUSY:    count_o = 2'd1;
         FULL:    count_o = 2'd2;
         default: count_o = 2'd0;
      endcase
   end

   assign in_ready_o = in_ready_q;
   assign out_data_o = main_q;

   pipe_data_reg #(.SIZE(SIZE)) u_main_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (main_en),
      .d_i   (main_d),
      .q_o   (main_q)
   );

   pipe_data_reg #(.SIZE(SIZE)) u_skid_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (skid_en),
      .d_i   (in_data_i),
      .q_o   (skid_q)
   );

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Directed and random checks of pipe_skid_reg (SIZE=32). The reference is a
//   queue of held payloads (at most two): its size gives count/ready/valid and
//   its head gives the expected out_data_o.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;
   import pipe_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic          flush;
   pipe_count_t   count;
   pipe_state_e   dbg_state;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_skid_reg #(.SIZE(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_ready_i (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
      .flush_i     (flush),
`endif
      .count_o     (count),
      .dbg_state_o (dbg_state)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_state(input int n);
      case (n)
         0:       return W'(EMPTY);
         1:       return W'(BUSY);
         default: return W'(FULL);
      endcase
   endfunction

   task automatic check_all();
      int n;
      n = exp_q.size();
      chk("out_valid", W'(out_valid), W'(n > 0));
      chk("count",     W'(count),     W'(n));
      chk("in_ready",  W'(in_ready),  W'(n < 2));
      chk("state",     W'(dbg_state), exp_state(n));
      if (n > 0) chk("out_data", out_data, exp_q[0]);
   endtask

   // One clock: drive, check before the edge, then advance the model.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
      logic acc, pop;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(negedge clk);
      check_all();
      acc = v && (exp_q.size() < 2);
      pop = r && (exp_q.size() > 0);
      @(posedge clk);
      #1;
      if (f) begin
         exp_q.delete();
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(d);
      end
   endtask

   initial begin
      logic v, r, f;
      logic [W-1:0] d;

      // Reset with live-looking input
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      out_ready = 1'b1;
      flush     = 1'b0;
      @(negedge clk);
      check_all();
      chk("rst_out_data", out_data, '0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);

      // Streaming with downstream always ready
      for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
      chk("stream_last", out_data, 32'h4);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Backpressure: A, B fill the stage, C is held off
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0);
      chk("bp_count", W'(count), 32'd2);
      chk("bp_ready", W'(in_ready), 32'd0);
      cycle(1'b1, 32'hC, 1'b0, 1'b0);
      cycle(1'b1, 32'hC, 1'b0, 1'b0);
      cycle(1'b1, 32'hC, 1'b1, 1'b0);
      cycle(1'b1, 32'hC, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Simultaneous accept and leave in BUSY
      cycle(1'b1, 32'h4, 1'b1, 1'b0);
      cycle(1'b1, 32'h5, 1'b1, 1'b0);
      chk("sim_data", out_data, 32'h5);
      cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_SKID_FLUSH_EN
      // Flush from FULL drops held payloads and the same-cycle input
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0);
      cycle(1'b1, 32'hC, 1'b0, 1'b1);
      chk("flush_valid", W'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
`endif

      // Reset in the middle of operation
      cycle(1'b1, 32'h11, 1'b0, 1'b0);
      cycle(1'b1, 32'h22, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_all();
      chk("midrst_data", out_data, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Random valid/ready pattern
      for (int i = 0; i < 10000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
`ifdef PIPE_SKID_FLUSH_EN
         f = ($urandom_range(0, 63) == 0);
`else
         f = 1'b0;
`endif
         d = $urandom;
         cycle(v, d, r, f);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pipe_skid_reg
